alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 32, giving the operand and HI/LO width (even, 8..64).
REQ-002 The block SHALL have parameter CW, default 4, giving the ALU control code width (fixed minimum 4).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  an instruction is offered.
REQ-006 The block SHALL have port in_ready  output  1  the block accepts the instruction this cycle.
REQ-007 The block SHALL have port opcode  input  6  instruction bits [31:26].
REQ-008 The block SHALL have port funct  input  6  instruction bits [5:0]; don't-care for non-R-type.
REQ-009 The block SHALL have port rs_val, rt_val  input  W  operands, used only by multiply/divide.
REQ-010 The block SHALL have port out_valid  output  1  alu_ctrl/illegal hold a decoded result.
REQ-011 The block SHALL have port out_ready  input  1  the downstream stage consumes the result.
REQ-012 The block SHALL have port alu_ctrl  output  CW  registered ALU control code.
REQ-013 The block SHALL have port illegal  output  1  the decoded instruction is unsupported.
REQ-014 The block SHALL have port md_busy  output  1  the multiply/divide sequencer is running.
REQ-015 The block SHALL have port hi, lo  output  W  multiply/divide result registers.

Function
REQ-016 A transfer SHALL occur when in_valid and in_ready are both high; alu_ctrl, illegal and out_valid SHALL be updated on that edge (1-cycle latency).
REQ-017 out_valid SHALL stay high, with alu_ctrl and illegal stable, until out_valid and out_ready are both high; out_valid SHALL clear on that edge unless a new transfer occurs on the same edge.
REQ-018 in_ready SHALL be (!out_valid || out_ready) && !stall, where stall is md_busy && the offered instruction is an MD or mfhi/mflo op.
REQ-019 R-type (opcode 000000) codes SHALL be: add/addu 0010, sub/subu 0110, and 0000, or 0001, xor 1101, nor 1100, slt 0111, sltu 1000, sll 1001, srl 1010, sra 1011.
REQ-020 I-type codes SHALL be: addi/addiu 0010, andi 0000, ori 0001, xori 1101, slti 0111, sltiu 1000, beq 0101, bne 0011, lw/sw 0010.
REQ-021 mfhi (funct 010000) SHALL decode to 1110; mflo (funct 010010) SHALL decode to 1111.
REQ-022 mult, multu, div, divu (funct 011000..011011) SHALL decode to 0100 and start the sequencer, latching rs_val, rt_val and op type on the transfer edge.
REQ-023 Any other opcode/funct SHALL produce alu_ctrl 0000 with illegal high; illegal SHALL be low for every supported instruction.
REQ-024 The sequencer SHALL have states IDLE and RUN: IDLE->RUN on MD transfer; RUN SHALL last exactly W cycles, processing one bit per cycle (shift-add multiply, restoring divide); RUN->IDLE on the edge at which hi/lo are written.
REQ-025 md_busy SHALL be high exactly while the state is RUN.
REQ-026 Multiply SHALL write the 2W-bit product to {hi,lo}; signed ops SHALL operate on magnitudes and apply two's-complement sign fix-up in the final cycle.
REQ-027 Divide SHALL write the quotient to lo and the remainder to hi; for signed ops, the quotient sign SHALL be sign(rs)^sign(rt) and the remainder SHALL take the sign of rs.
REQ-028 Divide by zero SHALL complete in W cycles with lo = all ones and hi = rs_val.
REQ-029 Signed div of most-negative by -1 SHALL give lo = most-negative and hi = 0.
REQ-030 hi/lo SHALL change only on the final RUN edge; non-MD instructions SHALL continue to flow while md_busy is high.

Reset
REQ-031 Asserting rst_n low SHALL immediately force out_valid=0, alu_ctrl=0, illegal=0, md_busy=0, hi=0, lo=0 and state IDLE, aborting any RUN in progress with no hi/lo update.
REQ-032 in_ready SHALL be 1 during and after reset, provided out_valid is 0.

Verification
REQ-033 The bench SHALL offer add (000000/100000) with out_ready=1; alu_ctrl=0010 and out_valid=1 SHALL appear the next cycle, with illegal=0.
REQ-034 The bench SHALL hold out_ready=0 while offering beq then ori; beq code 0101 SHALL hold, in_ready=0, and ori (0001) SHALL appear only after out_ready rises.
REQ-035 The bench SHALL issue mult with rs=-3 and rt=7 (W=32), then mflo next cycle; mflo SHALL stall 32 cycles, then {hi,lo}=0xFFFFFFFF_FFFFFFEB and alu_ctrl=1111 SHALL be produced.
REQ-036 The bench SHALL issue divu with rs=100 and rt=0; after 32 cycles lo=0xFFFFFFFF and hi=100; a following sub SHALL issue during RUN without stall.
REQ-037 The bench SHALL offer opcode 111111; alu_ctrl=0000 with illegal=1 SHALL result.
REQ-038 The bench SHALL drop rst_n at RUN cycle 10 of a div; md_busy, hi, lo and out_valid SHALL be 0 immediately, and a new div after release SHALL take a full 32 cycles.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Instruction decoder producing a registered ALU control code over a valid/ready
// handshake, plus a bit-serial multiply/divide unit that owns the HI/LO registers.
module alu_op_sequencer #(
    parameter int W  = 32,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    opcode,
    input  logic [5:0]    funct,
    input  logic [W-1:0]  rs_val,
    input  logic [W-1:0]  rt_val,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] alu_ctrl,
    output logic          illegal,
    output logic          md_busy,
    output logic [W-1:0]  hi,
    output logic [W-1:0]  lo
);

    localparam int CNTW = $clog2(W);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q;
    logic            out_valid_q;
    logic [CW-1:0]   ctrl_q;
    logic            illegal_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;

    logic [CNTW-1:0] cnt_q;
    logic            is_div_q;
    logic            neg_q;
    logic            neg_rem_q;
    logic            dz_q;
    logic [W-1:0]    rs_save_q;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    low_q;
    logic [W-1:0]    mcand_q;

    logic [3:0]      dec_code;
    logic            dec_illegal;
    logic            dec_md;
    logic            dec_mf;
    logic            xfer;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        dec_code    = 4'b0000;
        dec_illegal = 1'b1;
        dec_md      = 1'b0;
        dec_mf      = 1'b0;
        if (opcode == 6'b000000) begin
            unique case (funct)
                6'b100000, 6'b100001: begin dec_code = 4'b0010; dec_illegal = 1'b0; end
                6'b100010, 6'b100011: begin dec_code = 4'b0110; dec_illegal = 1'b0; end
                6'b100100:            begin dec_code = 4'b0000; dec_illegal = 1'b0; end
                6'b100101:            begin dec_code = 4'b0001; dec_illegal = 1'b0; end
                6'b100110:            begin dec_code = 4'b1101; dec_illegal = 1'b0; end
                6'b100111:            begin dec_code = 4'b1100; dec_illegal = 1'b0; end
                6'b101010:            begin dec_code = 4'b0111; dec_illegal = 1'b0; end
                6'b101011:            begin dec_code = 4'b1000; dec_illegal = 1'b0; end
                6'b000000:            begin dec_code = 4'b1001; dec_illegal = 1'b0; end
                6'b000010:            begin dec_code = 4'b1010; dec_illegal = 1'b0; end
                6'b000011:            begin dec_code = 4'b1011; dec_illegal = 1'b0; end
                6'b010000: begin dec_code = 4'b1110; dec_illegal = 1'b0; dec_mf = 1'b1; end
                6'b010010: begin dec_code = 4'b1111; dec_illegal = 1'b0; dec_mf = 1'b1; end
                6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                    dec_code    = 4'b0100;
                    dec_illegal = 1'b0;
                    dec_md      = 1'b1;
                end
                default: ;
            endcase
        end else begin
            unique case (opcode)
                6'b001000, 6'b001001: begin dec_code = 4'b0010; dec_illegal = 1'b0; end
                6'b001100:            begin dec_code = 4'b0000; dec_illegal = 1'b0; end
                6'b001101:            begin dec_code = 4'b0001; dec_illegal = 1'b0; end
                6'b001110:            begin dec_code = 4'b1101; dec_illegal = 1'b0; end
                6'b001010:            begin dec_code = 4'b0111; dec_illegal = 1'b0; end
                6'b001011:            begin dec_code = 4'b1000; dec_illegal = 1'b0; end
                6'b000100:            begin dec_code = 4'b0101; dec_illegal = 1'b0; end
                6'b000101:            begin dec_code = 4'b0011; dec_illegal = 1'b0; end
                6'b100011, 6'b101011: begin dec_code = 4'b0010; dec_illegal = 1'b0; end
                default: ;
            endcase
        end
    end

    // Only instructions that touch HI/LO (or start a new op) wait for the sequencer.
    assign in_ready = (!out_valid_q || out_ready) && !(md_busy && (dec_md || dec_mf));
    assign xfer     = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Operand preparation for the sequencer
    // ------------------------------------------------------------------
    logic           op_signed;
    logic           op_div;
    logic [W-1:0]   rs_mag;
    logic [W-1:0]   rt_mag;

    always_comb begin
        op_signed = ~funct[0];
        op_div    = funct[1];
        rs_mag    = (op_signed && rs_val[W-1]) ? (~rs_val + 1'b1) : rs_val;
        rt_mag    = (op_signed && rt_val[W-1]) ? (~rt_val + 1'b1) : rt_val;
    end

    // ------------------------------------------------------------------
    // One bit-step of shift-add multiply or restoring divide
    // ------------------------------------------------------------------
    logic [W:0]     add_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [W-1:0]   rem_step;
    logic [W-1:0]   low_step;
    logic [2*W-1:0] prod_mag;
    logic [W-1:0]   hi_fin;
    logic [W-1:0]   lo_fin;

    always_comb begin
        add_sum   = {1'b0, rem_q} + (low_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {rem_q, low_q[W-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        if (is_div_q) begin
            rem_step = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
            low_step = {low_q[W-2:0], ~div_diff[W]};
        end else begin
            rem_step = add_sum[W:1];
            low_step = {add_sum[0], low_q[W-1:1]};
        end

        prod_mag = {rem_step, low_step};
        if (is_div_q) begin
            if (dz_q) begin
                hi_fin = rs_save_q;
                lo_fin = '1;
            end else begin
                hi_fin = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
                lo_fin = neg_q     ? (~low_step + 1'b1) : low_step;
            end
        end else if (neg_q) begin
            {hi_fin, lo_fin} = ~prod_mag + 1'b1;
        end else begin
            {hi_fin, lo_fin} = prod_mag;
        end
    end

    // ------------------------------------------------------------------
    // Output register, sequencer FSM and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            rs_save_q   <= '0;
            rem_q       <= '0;
            low_q       <= '0;
            mcand_q     <= '0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                ctrl_q      <= CW'(dec_code);
                illegal_q   <= dec_illegal;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (xfer && dec_md) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        is_div_q  <= op_div;
                        neg_q     <= op_signed && (rs_val[W-1] ^ rt_val[W-1]);
                        neg_rem_q <= op_signed && rs_val[W-1];
                        dz_q      <= op_div && (rt_val == '0);
                        rs_save_q <= rs_val;
                        rem_q     <= '0;
                        // Multiply shifts the multiplier out of low_q; divide shifts the dividend.
                        low_q     <= op_div ? rs_mag : rt_mag;
                        mcand_q   <= op_div ? rt_mag : rs_mag;
                    end
                end
                RUN: begin
                    rem_q <= rem_step;
                    low_q <= low_step;
                    cnt_q <= cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(W - 1)) begin
                        hi_q    <= hi_fin;
                        lo_q    <= lo_fin;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign alu_ctrl  = ctrl_q;
    assign illegal   = illegal_q;
    assign md_busy   = (state_q == RUN);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes expected decode and HI/LO
// results into queues; a negedge monitor pops and compares as the DUT produces them.
module tb_alu_op_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  rt_val;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    alu_ctrl;
    logic          illegal;
    logic          md_busy;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    alu_op_sequencer #(.W(W), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
        .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
        .illegal(illegal), .md_busy(md_busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // Instruction table: kind 0 = plain ALU op, 1 = multiply/divide, 2 = mfhi/mflo
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] code;
        int         kind;
    } ent_t;

    ent_t tbl[30] = '{
        '{6'b000000, 6'b100000, 4'b0010, 0}, '{6'b000000, 6'b100001, 4'b0010, 0},
        '{6'b000000, 6'b100010, 4'b0110, 0}, '{6'b000000, 6'b100011, 4'b0110, 0},
        '{6'b000000, 6'b100100, 4'b0000, 0}, '{6'b000000, 6'b100101, 4'b0001, 0},
        '{6'b000000, 6'b100110, 4'b1101, 0}, '{6'b000000, 6'b100111, 4'b1100, 0},
        '{6'b000000, 6'b101010, 4'b0111, 0}, '{6'b000000, 6'b101011, 4'b1000, 0},
        '{6'b000000, 6'b000000, 4'b1001, 0}, '{6'b000000, 6'b000010, 4'b1010, 0},
        '{6'b000000, 6'b000011, 4'b1011, 0}, '{6'b000000, 6'b010000, 4'b1110, 2},
        '{6'b000000, 6'b010010, 4'b1111, 2}, '{6'b000000, 6'b011000, 4'b0100, 1},
        '{6'b000000, 6'b011001, 4'b0100, 1}, '{6'b000000, 6'b011010, 4'b0100, 1},
        '{6'b000000, 6'b011011, 4'b0100, 1}, '{6'b001000, 6'b000000, 4'b0010, 0},
        '{6'b001001, 6'b000000, 4'b0010, 0}, '{6'b001100, 6'b000000, 4'b0000, 0},
        '{6'b001101, 6'b000000, 4'b0001, 0}, '{6'b001110, 6'b000000, 4'b1101, 0},
        '{6'b001010, 6'b000000, 4'b0111, 0}, '{6'b001011, 6'b000000, 4'b1000, 0},
        '{6'b000100, 6'b000000, 4'b0101, 0}, '{6'b000101, 6'b000000, 4'b0011, 0},
        '{6'b100011, 6'b000000, 4'b0010, 0}, '{6'b101011, 6'b000000, 4'b0010, 0}
    };

    function automatic void lookup(input logic [5:0] op, input logic [5:0] fn,
                                   output logic [3:0] code, output logic ill, output int kind);
        code = 4'b0000;
        ill  = 1'b1;
        kind = 0;
        foreach (tbl[i]) begin
            if (tbl[i].op == op && (op != 6'b000000 || tbl[i].fn == fn)) begin
                code = tbl[i].code;
                ill  = 1'b0;
                kind = tbl[i].kind;
            end
        end
    endfunction

    // Reference multiply/divide with plain arithmetic; returns {hi, lo}
    function automatic logic [63:0] md_model(input logic [5:0] fn, input logic [31:0] rs,
                                             input logic [31:0] rt);
        longint          a, b, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        res = '0;
        case (fn[1:0])
            2'b00: begin a = $signed(rs); b = $signed(rt); res = a * b; end
            2'b01: begin ua = rs; ub = rt; res = ua * ub; end
            2'b10: begin
                if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
                else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
                else begin
                    a = $signed(rs); b = $signed(rt);
                    q = a / b; r = a % b;
                    res = {32'(r), 32'(q)};
                end
            end
            default: begin
                if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
                else begin
                    ua = rs; ub = rt;
                    res = {32'(ua % ub), 32'(ua / ub)};
                end
            end
        endcase
        return res;
    endfunction

    logic [4:0]  sb_q[$];
    logic [63:0] md_q[$];

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [4:0]  sb_exp;
    logic [63:0] md_exp;
    logic [31:0] cur_hi, cur_lo;
    int          busy_len;
    logic        was_busy;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            md_q.delete();
            cur_hi   = '0;
            cur_lo   = '0;
            busy_len = 0;
            was_busy = 1'b0;
        end else begin
            if (md_busy) busy_len++;
            if (was_busy && !md_busy) begin
                chk("md_run_length", 64'(busy_len), 64'(W));
                if (md_q.size() == 0) chk("unexpected_md_done", 64'd1, 64'd0);
                else begin
                    md_exp = md_q.pop_front();
                    cur_hi = md_exp[63:32];
                    cur_lo = md_exp[31:0];
                end
                busy_len = 0;
            end
            was_busy = md_busy;
            chk("hi", 64'(hi), 64'(cur_hi));
            chk("lo", 64'(lo), 64'(cur_lo));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
                else begin
                    sb_exp = sb_q.pop_front();
                    chk("alu_ctrl", 64'(alu_ctrl), 64'(sb_exp[4:1]));
                    chk("illegal", 64'(illegal), 64'(sb_exp[0]));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // out_ready driver (random backpressure when enabled)
    // ------------------------------------------------------------------
    int ready_mode = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode != 0) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, output int stalls);
        logic [3:0] code;
        logic       ill;
        int         kind;
        bit         done;
        lookup(op, fn, code, ill, kind);
        opcode   = op;
        funct    = fn;
        rs_val   = rs;
        rt_val   = rt;
        in_valid = 1'b1;
        stalls   = 0;
        done     = 1'b0;
        while (!done && stalls < 300) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back({code, ill});
                if (kind == 1) md_q.push_back(md_model(fn, rs, rt));
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int          st;
        int          n;
        int          idx;
        logic [5:0]  op, fn;
        logic [63:0] exp_md;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        funct     = '0;
        rs_val    = '0;
        rt_val    = '0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_md_busy", 64'(md_busy), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // add with out_ready high: result one cycle later
        out_ready = 1'b1;
        send(6'b000000, 6'b100000, 32'd5, 32'd6, st);
        chk("add_out_valid", 64'(out_valid), 64'd1);
        chk("add_ctrl", 64'(alu_ctrl), 64'b0010);
        chk("add_illegal", 64'(illegal), 64'd0);
        idle(2);

        // backpressure: beq held, ori waits for out_ready
        out_ready = 1'b0;
        send(6'b000100, 6'b010101, 32'd0, 32'd0, st);
        opcode   = 6'b001101;
        funct    = 6'b111000;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_beq_hold", 64'(alu_ctrl), 64'b0101);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(6'b001101, 6'b111000, 32'd0, 32'd0, st);
        chk("bp_stall_after_ready", 64'(st), 64'd0);
        chk("bp_ori_ctrl", 64'(alu_ctrl), 64'b0001);
        idle(2);

        // mult -3 * 7 then mflo stalls for the whole run
        send(6'b000000, 6'b011000, 32'hFFFF_FFFD, 32'd7, st);
        send(6'b000000, 6'b010010, 32'd0, 32'd0, st);
        chk("mflo_stall_cycles", 64'(st), 64'd32);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mflo_ctrl", 64'(alu_ctrl), 64'b1111);
        idle(2);

        // divu by zero; a sub flows through during the run
        send(6'b000000, 6'b011011, 32'd100, 32'd0, st);
        send(6'b000000, 6'b100010, 32'd1, 32'd2, st);
        chk("sub_no_stall", 64'(st), 64'd0);
        chk("sub_during_run_busy", 64'(md_busy), 64'd1);
        chk("sub_ctrl", 64'(alu_ctrl), 64'b0110);
        for (int i = 0; i < 100 && md_busy; i++) @(posedge clk);
        #1;
        chk("divz_done", 64'(md_busy), 64'd0);
        chk("divz_hilo", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
        idle(1);

        // illegal opcode
        send(6'b111111, 6'b100000, 32'd0, 32'd0, st);
        chk("illegal_ctrl", 64'(alu_ctrl), 64'd0);
        chk("illegal_flag", 64'(illegal), 64'd1);
        idle(2);

        // reset aborts a divide in progress
        send(6'b000000, 6'b011010, 32'd1000, 32'd7, st);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_pre_busy", 64'(md_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_md_busy", 64'(md_busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(6'b000000, 6'b011010, -32'd77, 32'd5, st);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!md_busy) break;
            n++;
        end
        chk("div_after_rst_len", 64'(n), 64'd32);
        exp_md = md_model(6'b011010, -32'd77, 32'd5);
        chk("div_after_rst_hilo", {hi, lo}, exp_md);
        @(posedge clk);
        #1;

        // randomized traffic with random backpressure
        ready_mode = 1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                idx = $urandom_range(0, 29);
                op  = tbl[idx].op;
                fn  = (tbl[idx].op == 6'b000000) ? tbl[idx].fn : 6'($urandom);
            end
            send(op, fn, pick_operand(), pick_operand(), st);
            idle($urandom_range(0, 2));
        end

        ready_mode = 0;
        out_ready  = 1'b1;
        idle(40);
        chk("drain_out_queue", 64'(sb_q.size()), 64'd0);
        chk("drain_md_queue", 64'(md_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
